ppu_write_queue: RTL and testbench

PPU_WRITE_QUEUE -- requirements
Module: ppu_write_queue

---
 rtl/ppu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/ppu_write_queue.sv | 114 +++++++++++
 tb/tb_ppu_write_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU write queue: the IRQ acknowledge address,
// the queued bus-write record and the drain FSM states.
package ppu_pkg;

  localparam logic [11:0] IRQ_ACK_ADDR = 12'hFFF;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } ppu_entry_t;

  localparam int ENTRY_W = $bits(ppu_entry_t);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } ppu_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy count.
// Overflowing pushes and underflowing pops are ignored.
module sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (level != '0);
  // When full, a push is still legal alongside a pop: the slot is freed at the same edge.
  assign do_push = push && ((level != FULL_LEVEL) || do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W + 1)'(1);
        2'b01:   level <= level - (PTR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ppu_write_queue.sv
// Buffers CPU writes to the PPU and replays them only during vertical blank,
// one per cycle; also raises a sticky vblank interrupt acknowledged at 0xFFF.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              writedata,
  input  logic [11:0]              address,
  input  logic                     write,
  input  logic                     chipselect,
  output logic                     waitrequest,
  input  logic                     vblank,
  output logic [11:0]              ppu_address,
  output logic [31:0]              ppu_write_data,
  output logic                     ppu_write,
  output logic                     ppu_chipselect,
  output logic                     irq,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  ppu_state_t       state_q;
  ppu_state_t       state_d;
  ppu_entry_t       wr_entry;
  ppu_entry_t       head;
  logic             bus_req;
  logic             is_ack;
  logic             full;
  logic             push;
  logic             pop;
  logic [LVL_W-1:0] level_after_pop;
  logic             vblank_d;

  assign bus_req     = chipselect && write && (address != IRQ_ACK_ADDR);
  assign is_ack      = chipselect && write && (address == IRQ_ACK_ADDR);
  assign full        = (level == FULL_LEVEL);
  assign waitrequest = bus_req && full;
  assign push        = bus_req && !full;
  assign wr_entry    = '{addr: address, data: writedata};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign level_after_pop = level - LVL_W'(pop);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vblank && (level != '0)) state_d = DRAIN;
      DRAIN:   if (!vblank || (level_after_pop == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The entering cycle already pops, which gives the two-cycle push-to-write latency.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = vblank && (level != '0);
      DRAIN:   pop = vblank && (level != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ppu_write      <= 1'b0;
      ppu_address    <= '0;
      ppu_write_data <= '0;
    end else begin
      ppu_write <= pop;
      if (pop) begin
        ppu_address    <= head.addr;
        ppu_write_data <= head.data;
      end
    end
  end

  assign ppu_chipselect = ppu_write;

  // vblank_d resets high so leaving reset inside blanking does not look like an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vblank_d <= 1'b1;
      irq      <= 1'b0;
    end else begin
      vblank_d <= vblank;
      if (vblank && !vblank_d)       irq <= 1'b1;
      else if (is_ack && writedata[0]) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_write_queue.sv
// Directed bench for ppu_write_queue: a per-cycle vector table for the basic
// drain/irq behaviour, then hand-written full, partial-drain and reset sequences.
module tb_ppu_write_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata;
  logic [11:0] address;
  logic        write;
  logic        chipselect;
  logic        waitrequest;
  logic        vblank;
  logic [11:0] ppu_address;
  logic [31:0] ppu_write_data;
  logic        ppu_write;
  logic        ppu_chipselect;
  logic        irq;
  logic [4:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  logic [43:0] got [$];

  typedef struct {
    logic        cs;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        vb;
    logic        e_wait;
    logic        e_pw;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic [4:0]  e_level;
    logic        e_irq;
  } vec_t;

  vec_t vq [$];

  ppu_write_queue #(.DEPTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .writedata      (writedata),
    .address        (address),
    .write          (write),
    .chipselect     (chipselect),
    .waitrequest    (waitrequest),
    .vblank         (vblank),
    .ppu_address    (ppu_address),
    .ppu_write_data (ppu_write_data),
    .ppu_write      (ppu_write),
    .ppu_chipselect (ppu_chipselect),
    .irq            (irq),
    .level          (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && ppu_write) got.push_back({ppu_address, ppu_write_data});
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic wr, input logic [11:0] a, input logic [31:0] d);
    chipselect = cs;
    write      = wr;
    address    = a;
    writedata  = d;
  endtask

  task automatic add(input logic cs, input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic vb, input logic e_wait, input logic e_pw, input logic [11:0] e_addr,
                     input logic [31:0] e_data, input logic [4:0] e_level, input logic e_irq);
    vec_t v;
    v = '{cs, wr, a, d, vb, e_wait, e_pw, e_addr, e_data, e_level, e_irq};
    vq.push_back(v);
  endtask

  task automatic apply_reset(input logic vb);
    reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    vblank = vb;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_drained();
    for (int k = 0; k < 60; k++) begin
      if (level == 5'd0 && !ppu_write) break;
      tick();
    end
    tick();
  endtask

  initial begin
    logic [43:0] exp_e;

    // cs wr addr data vb | wait pw addr data level irq
    add(0, 0, 12'h000, 32'h00000000, 0,  0, 0, 12'h000, 32'h00000000, 5'd0, 0);
    add(1, 1, 12'h010, 32'hAAAA0001, 0,  0, 0, 12'h000, 32'h00000000, 5'd1, 0);
    add(1, 1, 12'h011, 32'hAAAA0002, 0,  0, 0, 12'h000, 32'h00000000, 5'd2, 0);
    add(1, 1, 12'h012, 32'hAAAA0003, 0,  0, 0, 12'h000, 32'h00000000, 5'd3, 0);
    add(0, 0, 12'h000, 32'h00000000, 1,  0, 1, 12'h010, 32'hAAAA0001, 5'd2, 1);
    add(0, 0, 12'h000, 32'h00000000, 1,  0, 1, 12'h011, 32'hAAAA0002, 5'd1, 1);
    add(0, 0, 12'h000, 32'h00000000, 1,  0, 1, 12'h012, 32'hAAAA0003, 5'd0, 1);
    add(0, 0, 12'h000, 32'h00000000, 1,  0, 0, 12'h012, 32'hAAAA0003, 5'd0, 1);
    add(1, 1, 12'hFFF, 32'h00000000, 1,  0, 0, 12'h012, 32'hAAAA0003, 5'd0, 1);
    add(1, 1, 12'hFFF, 32'h00000001, 1,  0, 0, 12'h012, 32'hAAAA0003, 5'd0, 0);
    add(0, 0, 12'h000, 32'h00000000, 0,  0, 0, 12'h012, 32'hAAAA0003, 5'd0, 0);
    add(1, 1, 12'hFFF, 32'h00000001, 1,  0, 0, 12'h012, 32'hAAAA0003, 5'd0, 1);
    add(1, 1, 12'h020, 32'hBBBB0000, 1,  0, 0, 12'h012, 32'hAAAA0003, 5'd1, 1);
    add(0, 0, 12'h000, 32'h00000000, 1,  0, 1, 12'h020, 32'hBBBB0000, 5'd0, 1);
    add(0, 0, 12'h000, 32'h00000000, 0,  0, 0, 12'h020, 32'hBBBB0000, 5'd0, 1);
    add(1, 1, 12'hFFF, 32'h00000003, 0,  0, 0, 12'h020, 32'hBBBB0000, 5'd0, 0);

    // Reset state
    reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    vblank = 1'b0;
    repeat (3) tick();
    check("rst_level", 64'(level), 64'd0);
    check("rst_ppu_write", 64'(ppu_write), 64'd0);
    check("rst_ppu_cs", 64'(ppu_chipselect), 64'd0);
    check("rst_ppu_addr", 64'(ppu_address), 64'd0);
    check("rst_ppu_data", 64'(ppu_write_data), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_wait", 64'(waitrequest), 64'd0);
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].cs, vq[i].wr, vq[i].addr, vq[i].data);
      vblank = vq[i].vb;
      #1;
      check($sformatf("v%0d_wait", i), 64'(waitrequest), 64'(vq[i].e_wait));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pw", i), 64'(ppu_write), 64'(vq[i].e_pw));
      check($sformatf("v%0d_pcs", i), 64'(ppu_chipselect), 64'(vq[i].e_pw));
      check($sformatf("v%0d_addr", i), 64'(ppu_address), 64'(vq[i].e_addr));
      check($sformatf("v%0d_data", i), 64'(ppu_write_data), 64'(vq[i].e_data));
      check($sformatf("v%0d_level", i), 64'(level), 64'(vq[i].e_level));
      check($sformatf("v%0d_irq", i), 64'(irq), 64'(vq[i].e_irq));
    end

    // Fill to DEPTH, stall the 17th, then drain everything (pointers wrap)
    apply_reset(1'b0);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 12'(12'h100 + i), 32'hC0DE0000 + 32'(i));
      tick();
    end
    check("full_level", 64'(level), 64'd16);
    drive(1'b1, 1'b1, 12'h110, 32'hC0DE0010);
    #1;
    check("full_wait", 64'(waitrequest), 64'd1);
    tick();
    check("full_no_accept", 64'(level), 64'd16);
    vblank = 1'b1;
    #1;
    check("full_wait_pop_cycle", 64'(waitrequest), 64'd1);
    tick();
    check("full_after_pop_level", 64'(level), 64'd15);
    check("full_wait_released", 64'(waitrequest), 64'd0);
    tick();
    check("full_push_pop_level", 64'(level), 64'd15);
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    wait_drained();
    vblank = 1'b0;
    check("full_count", 64'(got.size()), 64'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      exp_e = {12'(12'h100 + i), 32'hC0DE0000 + 32'(i)};
      check($sformatf("full_entry%0d", i), 64'(got[i]), 64'(exp_e));
    end

    // Partial drain: vblank high for 4 cycles with 10 queued
    apply_reset(1'b0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 12'(12'h200 + i), 32'hD0000000 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    vblank = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vblank = 1'b0;
    repeat (3) tick();
    check("part_level", 64'(level), 64'd6);
    check("part_count", 64'(got.size()), 64'd4);
    vblank = 1'b1;
    wait_drained();
    vblank = 1'b0;
    check("part_total", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      exp_e = {12'(12'h200 + i), 32'hD0000000 + 32'(i)};
      check($sformatf("part_entry%0d", i), 64'(got[i]), 64'(exp_e));
    end

    // Reset while draining with 5 entries left, release inside vblank
    apply_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 12'(12'h300 + i), 32'hE0000000 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    vblank = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rd_pre_level", 64'(level), 64'd5);
    check("rd_pre_irq", 64'(irq), 64'd1);
    reset = 1'b0;
    repeat (2) tick();
    check("rd_level", 64'(level), 64'd0);
    check("rd_pw", 64'(ppu_write), 64'd0);
    check("rd_pcs", 64'(ppu_chipselect), 64'd0);
    check("rd_irq", 64'(irq), 64'd0);
    got.delete();
    reset = 1'b1;
    tick();
    check("rd_first_cycle_pw", 64'(ppu_write), 64'd0);
    repeat (4) tick();
    check("rd_no_writes", 64'(got.size()), 64'd0);
    check("rd_no_irq", 64'(irq), 64'd0);
    check("rd_level_after", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
